// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with start/done handshake, stall, branch and call/return stack.
// Optional macro PC_SEQ_CYCLE_COUNT_EN adds the saturating run_cycles counter output.
module pc_sequencer #(
   parameter int D = 12,
   parameter int W = 9,
   parameter int SD = 4,
   parameter int START_ADDR = 0,
   localparam int DW = $clog2(SD + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic [W-1:0]  instr,
   input  logic          branch_en,
   input  logic          call_en,
   input  logic          ret_en,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  prog_ctr,
   output logic          busy,
   output logic          done,
   output logic          stack_err,
   output logic [DW-1:0] depth
`ifdef PC_SEQ_CYCLE_COUNT_EN
   ,output logic [15:0]  run_cycles
`endif
);
   localparam int AW = SD > 1 ? $clog2(SD) : 1;
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t state;
   logic [D-1:0] stk [2**AW];
   logic [D-1:0] pc_inc;
   logic [DW-1:0] depth_dec;
   logic full, push;
   assign pc_inc = prog_ctr + 1'b1;
   assign depth_dec = depth - 1'b1;
   assign full = depth == DW'(SD);
   assign push = state == RUN && !stall && instr != '0 && !ret_en && call_en && !full;
   // Stack storage is unreset; depth alone decides which entries are live.
   always_ff @(posedge clk)
      if (push) stk[depth[AW-1:0]] <= pc_inc;
   // Control FSM: PC sequencing, handshake outputs, stack occupancy and sticky error.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         prog_ctr  <= D'(START_ADDR);
         busy      <= 1'b0;
         done      <= 1'b0;
         stack_err <= 1'b0;
         depth     <= '0;
      end else begin
         case (state)
            IDLE, HALT:
               if (start) begin
                  state     <= RUN;
                  prog_ctr  <= D'(START_ADDR);
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  stack_err <= 1'b0;
                  depth     <= '0;
               end
            RUN:
               if (!stall) begin
                  if (instr == '0) begin
                     state <= HALT;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (ret_en) begin
                     prog_ctr <= depth != '0 ? stk[depth_dec[AW-1:0]] : pc_inc;
                     if (depth != '0) depth <= depth_dec;
                     else stack_err <= 1'b1;
                  end else if (call_en) begin
                     prog_ctr <= target;
                     if (!full) depth <= depth + 1'b1;
                     else stack_err <= 1'b1;
                  end else prog_ctr <= branch_en ? target : pc_inc;
               end
            default: state <= IDLE;
         endcase
      end
`ifdef PC_SEQ_CYCLE_COUNT_EN
   // Counts unstalled RUN cycles, saturating; cleared whenever a start is accepted.
   always_ff @(posedge clk or negedge reset)
      if (!reset) run_cycles <= '0;
      else if (state != RUN && start) run_cycles <= '0;
      else if (state == RUN && !stall && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a queue-based reference model of the sequencer.
module tb_pc_sequencer;
   localparam int D = 12, W = 9, SD = 4, DW = $clog2(SD + 1);
   localparam int P_IDLE = 0, P_RUN = 1, P_HALT = 2;
   logic clk = 0, reset = 0, start = 0, stall = 0, branch_en = 0, call_en = 0, ret_en = 0;
   logic [W-1:0] instr = '0;
   logic [D-1:0] target = '0;
   logic [D-1:0] prog_ctr;
   logic busy, done, stack_err;
   logic [DW-1:0] depth;
   logic [15:0] cyc_act;
   logic r4 = 0, s4 = 0, b4 = 0;
   logic [W-1:0] i4 = '0;
   logic [3:0] t4 = '0, pc4;
   logic busy4, done4, err4;
   logic [DW-1:0] depth4;
`ifdef PC_SEQ_CYCLE_COUNT_EN
   logic [15:0] run_cycles, rc4;
   assign cyc_act = run_cycles;
`else
   assign cyc_act = '0;
`endif
   pc_sequencer #(.D(D), .W(W), .SD(SD), .START_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .instr(instr),
      .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en), .target(target),
      .prog_ctr(prog_ctr), .busy(busy), .done(done), .stack_err(stack_err), .depth(depth)
`ifdef PC_SEQ_CYCLE_COUNT_EN
      , .run_cycles(run_cycles)
`endif
   );
   pc_sequencer #(.D(4), .W(W), .SD(SD), .START_ADDR(0)) dut4 (
      .clk(clk), .reset(r4), .start(s4), .stall(1'b0), .instr(i4),
      .branch_en(b4), .call_en(1'b0), .ret_en(1'b0), .target(t4),
      .prog_ctr(pc4), .busy(busy4), .done(done4), .stack_err(err4), .depth(depth4)
`ifdef PC_SEQ_CYCLE_COUNT_EN
      , .run_cycles(rc4)
`endif
   );
   always #5 clk = ~clk;

   typedef struct {
      logic [D-1:0] pc;
      logic busy, done, err;
      logic [DW-1:0] depth;
      logic [15:0] cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;
   int checks = 0, passes = 0, cyc_no = 0;
   int ph = P_IDLE, m_pc = 0, m_cyc = 0;
   int m_stk[$];
   bit m_err = 0;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %h expected %h", n, got, want);
   endtask

   // Drive one cycle of inputs and record what the outputs must be after the next edge.
   task automatic step(input bit r, input bit s, input bit st, input int ins,
                       input bit b, input bit c, input bit rt, input int t);
      exp_t x;
      @(negedge clk);
      reset = r; start = s; stall = st; instr = W'(ins);
      branch_en = b; call_en = c; ret_en = rt; target = D'(t);
      if (!r) begin
         ph = P_IDLE; m_pc = 0; m_stk.delete(); m_err = 0; m_cyc = 0;
      end else if (ph != P_RUN) begin
         if (s) begin
            ph = P_RUN; m_pc = 0; m_stk.delete(); m_err = 0; m_cyc = 0;
         end
      end else if (!st) begin
         if (m_cyc < 65535) m_cyc++;
         if (ins == 0) ph = P_HALT;
         else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_err = 1; m_pc = (m_pc + 1) % (1 << D); end
         end else if (c) begin
            if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % (1 << D));
            else m_err = 1;
            m_pc = t % (1 << D);
         end else m_pc = b ? t % (1 << D) : (m_pc + 1) % (1 << D);
      end
      x.pc = D'(m_pc); x.busy = ph == P_RUN; x.done = ph == P_HALT; x.err = m_err;
      x.depth = DW'(m_stk.size());
`ifdef PC_SEQ_CYCLE_COUNT_EN
      x.cyc = 16'(m_cyc);
`else
      x.cyc = '0;
`endif
      exp_q.push_back(x);
   endtask

   task automatic run(input int ins, input bit b, input bit c, input bit rt, input int t);
      step(1, 0, 0, ins, b, c, rt, t);
   endtask

   // Monitor: one expectation per clock edge, compared just after the edge.
   always @(posedge clk) begin
      #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (prog_ctr === e.pc && busy === e.busy && done === e.done && stack_err === e.err &&
             depth === e.depth && cyc_act === e.cyc)
            passes++;
         else
            $display("FAIL cycle%0d: got pc=%h busy=%b done=%b err=%b depth=%0d rc=%0d expected pc=%h busy=%b done=%b err=%b depth=%0d rc=%0d",
                     cyc_no, prog_ctr, busy, done, stack_err, depth, cyc_act,
                     e.pc, e.busy, e.done, e.err, e.depth, e.cyc);
      end
   end

   initial begin
      // Narrow instance: PC wraps from all-ones to zero.
      @(negedge clk); r4 = 1; s4 = 1; i4 = 1;
      @(posedge clk); #1 chk("d4_start_pc", 32'(pc4), 0);
      @(negedge clk); s4 = 0; b4 = 1; t4 = 4'hF;
      @(posedge clk); #1 chk("d4_branch_pc", 32'(pc4), 32'hF);
      @(negedge clk); b4 = 0;
      @(posedge clk); #1 chk("d4_wrap_pc", 32'(pc4), 0);
      chk("d4_busy", 32'(busy4), 1);
      // Reset state, then straight-line run to halt.
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) run(i, 0, 0, 0, 0);
      run(0, 1, 1, 1, 'h77);
      run(3, 0, 0, 0, 0);
      step(1, 0, 1, 3, 0, 0, 0, 0);
      // Call and return.
      step(1, 1, 0, 1, 0, 0, 0, 0);
      repeat (3) run(1, 0, 0, 0, 0);
      run(1, 0, 1, 0, 'h40);
      repeat (2) run(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 1, 0);
      // Overflow on the fifth nested call, underflow on the fifth return.
      for (int i = 1; i <= 5; i++) run(1, 0, 1, 0, i * 'h100);
      for (int i = 0; i < 5; i++) run(1, 0, 0, 1, 0);
      run(0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0, 0);
      // All three flow-control enables at once with one stacked entry.
      run(1, 1, 0, 0, 'hF);
      run(1, 0, 1, 0, 'h80);
      run(1, 1, 1, 1, 'h300);
      // Stall holds a pending branch.
      run(1, 1, 0, 0, 7);
      repeat (3) step(1, 0, 1, 1, 1, 0, 0, 'h55);
      run(1, 1, 0, 0, 'h55);
      run(1, 0, 0, 0, 0);
      run(1, 1, 0, 0, 'hFFF);
      run(1, 0, 0, 0, 0);
      // Asynchronous reset between clock edges.
      run(1, 1, 0, 0, 'h2A);
      @(posedge clk); #3;
      reset = 0;
      #1;
      chk("async_reset", {prog_ctr, busy, done, stack_err, 16'(depth)}, '0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      // Randomised traffic.
      for (int n = 0; n < 600; n++)
         step($urandom_range(99) != 0, $urandom_range(5) == 0, $urandom_range(3) == 0,
              $urandom_range(11) == 0 ? 0 : int'($urandom_range(511, 1)),
              $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
              int'($urandom_range(4095)));
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the core's fetch subassembly: program-counter sequencer with start/done handshake, stall, absolute branch, and a hardware call/return stack.
- Sits between the control decoder and the instruction ROM: drives prog_ctr and reads back the fetched instruction word.
- The halt condition (all-zero instruction) is detected here, so the core top level no longer decodes done.

Parameters:
- D, 12, program counter width.
- W, 9, instruction word width.
- SD, 4, call-stack depth (entries, >=1).
- START_ADDR, 0, PC value loaded at reset and on every start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin execution at START_ADDR; sampled in IDLE and HALT only.
- stall  input  1  freeze PC, stack and halt detection this cycle.
- instr  input  W  instruction currently addressed by prog_ctr.
- branch_en  input  1  absolute jump to target.
- call_en  input  1  push prog_ctr+1, then jump to target.
- ret_en  input  1  pop stack into PC.
- target  input  D  branch/call destination.
- prog_ctr  output  D  current PC.
- busy  output  1  high in RUN.
- done  output  1  high in HALT.
- stack_err  output  1  sticky overflow/underflow flag.
- depth  output  $clog2(SD+1)  current stack occupancy.

Behaviour:
- Reset (reset=0, async): state=IDLE, prog_ctr=START_ADDR, busy=0, done=0, stack_err=0, depth=0. All outputs are registered.
- States: IDLE, RUN, HALT.
- IDLE: start=1 -> RUN next cycle with prog_ctr=START_ADDR.
- RUN, stall=1: all state is held.
- RUN, stall=0, instr==0: -> HALT next cycle, done=1, busy=0, prog_ctr held. Flow-control inputs are ignored.
- RUN, stall=0, instr!=0: next PC by priority ret_en > call_en > branch_en > prog_ctr+1.
- PC arithmetic: prog_ctr+1 wraps modulo 2^D (all-ones -> 0).
- call when depth<SD: push prog_ctr+1 (wrapped), depth+1, PC=target.
- call when depth==SD: no push, stack_err<=1, PC=target.
- ret when depth>0: PC=top entry, depth-1.
- ret when depth==0: stack_err<=1, PC=prog_ctr+1.
- Simultaneous enables: only the highest-priority action takes effect. Lower-priority enables have no side effect (no push, no error).
- HALT: start=1 -> RUN at START_ADDR. Same cycle: done<=0, depth<=0, stack_err<=0. Without start, HALT holds indefinitely.
- start while in RUN: ignored.
- Reset asserted mid-RUN: immediate return to reset values. Stack contents need not be cleared; depth=0 makes them unreachable.

Optional Feature:
- Macro PC_SEQ_CYCLE_COUNT_EN.
- Defined: extra output run_cycles, 16 bits. Cleared on reset and on each start. Increments every RUN cycle with stall=0, including the halting cycle. Saturates at 16'hFFFF. Held in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start, instr nonzero for 5 cycles then 0 -> prog_ctr 0,1,2,3,4,5. HALT entered after the instr==0 cycle. done=1, busy=0, prog_ctr stays 5.
- RUN at pc=3, call_en with target=0x40 -> pc=0x40, depth=1. Two cycles later ret_en -> pc=4, depth=0.
- SD=4: five nested calls -> depth=4, stack_err=1, fifth jump still taken. Then four rets return correct addresses; fifth ret -> pc increments, stack_err stays 1.
- ret_en, call_en and branch_en together with depth=1 (top=0x10) -> pc=0x10, depth=0, no push.
- stall held 3 cycles at pc=7 with branch_en=1 -> pc stays 7. On release, pc=target.
- Assert reset low mid-RUN at pc=0x2A, asynchronously between clock edges -> outputs reset immediately. With D=4, pc 0xF +1 -> 0x0.
